// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
//
// Loopback monitor for a multiplexed 4-digit, active-low 7-segment display.
// It watches the same an/seg lines that drive the board, waits for each digit
// to dwell long enough to be trusted (rejecting mux-transition ghosts), decodes
// the glyph back to a hex nibble, and reports every complete 4-digit frame.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   an[3:0]      active-low digit enables, an[k]=0 selects digit k (0 = LSD)
//   seg[6:0]     active-low segments, bit0=a ... bit6=g
//   frame_value  last completed frame, digit k in bits [4k+3:4k]
//   frame_valid  one-cycle pulse when frame_value updates
//   bad_seg      one-cycle pulse when a captured pattern is not a hex glyph
//
// Handshake: there is none on the input side; an/seg are free-running display
// lines. frame_valid and bad_seg are single-cycle strobes with no ready; a
// consumer that misses a strobe simply misses that event.

module seg7_frame_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] frame_value,
    output logic        frame_valid,
    output logic        bad_seg
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    // Input stage and the previous-cycle copy used for the dwell compare.
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic [3:0]  p_an;
    logic [6:0]  p_seg;
    logic [7:0]  dwell_cnt;

    // Partial-frame state.
    logic [3:0]  seen;
    logic [15:0] nibbles;

    // Next-state signals.
    logic [7:0]  dwell_next;
    logic [3:0]  seen_next;
    logic [15:0] nibbles_next;
    logic [15:0] frame_next;
    logic        frame_valid_next;
    logic        bad_seg_next;

    logic        same;
    logic        fire;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic        glyph_ok;
    logic [3:0]  glyph_val;

    // Decode an active-low segment pattern; bit 4 of the result flags a legal glyph.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pattern);
        logic [4:0] r;
        case (pattern)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Only a single active anode identifies a digit; blank or overlapping
    // enables are ignored entirely.
    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (s_an)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign {glyph_ok, glyph_val} = decode_glyph(s_seg);

    assign same = (s_an == p_an) && (s_seg == p_seg);

    // Fires only on the step into STABLE; a saturated counter stays put and
    // therefore cannot fire again for the same dwell.
    assign fire = same && (dwell_cnt == STABLE - 8'd1);

    always_comb begin
        dwell_next       = 8'd1;
        seen_next        = seen;
        nibbles_next     = nibbles;
        frame_next       = frame_value;
        frame_valid_next = 1'b0;
        bad_seg_next     = 1'b0;

        if (same) begin
            dwell_next = (dwell_cnt == STABLE) ? dwell_cnt : dwell_cnt + 8'd1;
        end

        if (fire && sel_ok) begin
            if (glyph_ok) begin
                nibbles_next[{sel_idx, 2'b00} +: 4] = glyph_val;
                seen_next = seen | (4'b0001 << sel_idx);
                // The frame includes the nibble captured on this very edge.
                if (seen_next == 4'hF) begin
                    frame_next       = nibbles_next;
                    frame_valid_next = 1'b1;
                    seen_next        = 4'h0;
                end
            end else begin
                // Corrupt digit: force it to be resent before the frame can close.
                bad_seg_next = 1'b1;
                seen_next    = seen & ~(4'b0001 << sel_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_an        <= 4'hF;
            s_seg       <= 7'h7F;
            p_an        <= 4'hF;
            p_seg       <= 7'h7F;
            dwell_cnt   <= 8'd0;
            seen        <= 4'h0;
            nibbles     <= 16'h0000;
            frame_value <= 16'h0000;
            frame_valid <= 1'b0;
            bad_seg     <= 1'b0;
        end else begin
            s_an        <= an;
            s_seg       <= seg;
            p_an        <= s_an;
            p_seg       <= s_seg;
            dwell_cnt   <= dwell_next;
            seen        <= seen_next;
            nibbles     <= nibbles_next;
            frame_value <= frame_next;
            frame_valid <= frame_valid_next;
            bad_seg     <= bad_seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
module tb_seg7_frame_decoder;

    localparam int S = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] frame_value;
    logic        frame_valid;
    logic        bad_seg;

    int checks = 0;
    int errors = 0;

    seg7_frame_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .frame_value (frame_value),
        .frame_valid (frame_valid),
        .bad_seg     (bad_seg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Works on whole "holds": a run of identical (an,seg) values lasting some
    // number of clock edges. A run that lasts STABLE edges is trusted.
    logic [6:0]  glyph [16];
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    int          m_len;
    logic [3:0]  m_seen;
    logic [3:0]  m_nib [4];
    logic [15:0] exp_q [$];
    int          exp_bad;

    // Observed events.
    logic [15:0] got_q [$];
    int          got_bad;
    logic        mon_en = 1'b0;

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    end

    task automatic model_reset();
        m_an   = 4'hF;
        m_seg  = 7'h7F;
        m_len  = 0;
        m_seen = 4'h0;
    endtask

    task automatic model_hold(input logic [3:0] a, input logic [6:0] sg, input int n);
        int old_len;
        int k;
        int found;
        if (a == m_an && sg == m_seg) begin
            old_len = m_len;
            m_len   = m_len + n;
        end else begin
            old_len = 0;
            m_an    = a;
            m_seg   = sg;
            m_len   = n;
        end
        if (old_len < S && m_len >= S && $countones(~a) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) k = i;
            found = -1;
            for (int v = 0; v < 16; v++) if (glyph[v] == sg) found = v;
            if (found >= 0) begin
                m_nib[k]  = found[3:0];
                m_seen[k] = 1'b1;
                if (m_seen == 4'hF) begin
                    exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
                    m_seen = 4'h0;
                end
            end else begin
                exp_bad++;
                m_seen[k] = 1'b0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (frame_valid === 1'b1 && bad_seg === 1'b1) begin
                errors++;
                $display("FAIL pulse_exclusive frame_valid=%b bad_seg=%b required not both", frame_valid, bad_seg);
            end
            if (frame_valid === 1'b1) got_q.push_back(frame_value);
            if (bad_seg === 1'b1) got_bad++;
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; holds the pair for n edges.
    task automatic drive_hold(input logic [3:0] a, input logic [6:0] sg, input int n);
        an  = a;
        seg = sg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        model_hold(a, sg, n);
    endtask

    task automatic clear_scoreboard();
        exp_q.delete();
        got_q.delete();
        exp_bad = 0;
        got_bad = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            an  = 4'($urandom);
            seg = 7'($urandom);
            @(posedge clk);
            #1;
        end
        checks++;
        if (frame_value !== 16'h0000 || frame_valid !== 1'b0 || bad_seg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state value=%h fv=%b bad=%b required 0000 0 0", frame_value, frame_valid, bad_seg);
        end
        an    = 4'hF;
        seg   = 7'h7F;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_value !== 16'h0000 || frame_valid !== 1'b0 || bad_seg !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet cycle %0d value=%h fv=%b bad=%b required 0000 0 0",
                         i, frame_value, frame_valid, bad_seg);
            end
        end
        model_hold(4'hF, 7'h7F, 10);
        clear_scoreboard();
        mon_en = 1'b1;
    endtask

    task automatic test_nominal();
        clear_scoreboard();
        drive_hold(4'b0111, glyph[1], 8);
        drive_hold(4'b1011, glyph[2], 8);
        drive_hold(4'b1101, glyph[3], 8);
        // Digit 0 stepped by hand to check the exact pulse cycle.
        an  = 4'b1110;
        seg = glyph[4];
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_valid !== (i == S + 1)) begin
                errors++;
                $display("FAIL nominal_latency edge %0d frame_valid=%b required %b", i, frame_valid, (i == S + 1));
            end
        end
        model_hold(4'b1110, glyph[4], 8);
        checks++;
        if (frame_value !== 16'h1234) begin
            errors++;
            $display("FAIL nominal_1234 value=%h required 1234", frame_value);
        end
        drive_hold(4'b0111, glyph[10], 8);
        drive_hold(4'b1011, glyph[11], 8);
        drive_hold(4'b1101, glyph[12], 8);
        drive_hold(4'b1110, glyph[13], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (frame_value !== 16'hABCD) begin
            errors++;
            $display("FAIL nominal_abcd value=%h required abcd", frame_value);
        end
        checks++;
        if (got_q.size() != exp_q.size() || got_bad != exp_bad) begin
            errors++;
            $display("FAIL nominal_events frames=%0d bad=%0d required frames=%0d bad=%0d",
                     got_q.size(), got_bad, exp_q.size(), exp_bad);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL nominal_frame[%0d] value=%h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_ghost();
        clear_scoreboard();
        drive_hold(4'b1110, 7'b0000000, S - 1);
        drive_hold(4'hF, 7'h7F, 1);
        drive_hold(4'b0111, glyph[15], 8);
        drive_hold(4'b1011, glyph[14], 8);
        drive_hold(4'b1101, glyph[0], 8);
        drive_hold(4'b1110, glyph[9], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (frame_value !== 16'hFE09) begin
            errors++;
            $display("FAIL ghost_value value=%h required fe09", frame_value);
        end
        checks++;
        if (got_q.size() != 1 || got_bad != 0 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL ghost_events frames=%0d bad=%0d required frames=1 bad=0", got_q.size(), got_bad);
        end
    endtask

    task automatic test_illegal();
        clear_scoreboard();
        drive_hold(4'b0111, glyph[5], 8);
        drive_hold(4'b1011, 7'b1111111, 8);
        drive_hold(4'b1101, glyph[6], 8);
        drive_hold(4'b1110, glyph[7], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (got_q.size() != 0 || got_bad != 1 || frame_value !== 16'hFE09) begin
            errors++;
            $display("FAIL illegal_pending frames=%0d bad=%0d value=%h required frames=0 bad=1 value=fe09",
                     got_q.size(), got_bad, frame_value);
        end
        drive_hold(4'b1011, glyph[8], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (got_q.size() != 1 || frame_value !== 16'h5867) begin
            errors++;
            $display("FAIL illegal_resend frames=%0d value=%h required frames=1 value=5867", got_q.size(), frame_value);
        end
        checks++;
        if (got_q.size() != exp_q.size() || got_bad != exp_bad) begin
            errors++;
            $display("FAIL illegal_model frames=%0d bad=%0d required frames=%0d bad=%0d",
                     got_q.size(), got_bad, exp_q.size(), exp_bad);
        end
    endtask

    task automatic test_invalid_anode();
        clear_scoreboard();
        drive_hold(4'b0111, glyph[3], 8);
        drive_hold(4'b1011, glyph[1], 8);
        drive_hold(4'b1101, glyph[4], 8);
        drive_hold(4'b1100, glyph[2], 20);
        drive_hold(4'hF, glyph[9], 20);
        checks++;
        if (got_q.size() != 0 || got_bad != 0) begin
            errors++;
            $display("FAIL invalid_anode_quiet frames=%0d bad=%0d required 0 0", got_q.size(), got_bad);
        end
        drive_hold(4'b1110, glyph[1], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (got_q.size() != 1 || frame_value !== 16'h3141) begin
            errors++;
            $display("FAIL invalid_anode_frame frames=%0d value=%h required frames=1 value=3141",
                     got_q.size(), frame_value);
        end
    endtask

    task automatic test_reset_mid();
        clear_scoreboard();
        drive_hold(4'b0111, glyph[9], 8);
        drive_hold(4'b1011, glyph[9], 8);
        drive_hold(4'b1101, glyph[9], 8);
        drive_hold(4'hF, 7'h7F, 3);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
        drive_hold(4'b1110, glyph[7], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (got_q.size() != 0 || frame_value !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_discard frames=%0d value=%h required frames=0 value=0000",
                     got_q.size(), frame_value);
        end
        drive_hold(4'b0111, glyph[0], 8);
        drive_hold(4'b1011, glyph[0], 8);
        drive_hold(4'b1101, glyph[0], 8);
        drive_hold(4'b1110, glyph[7], 8);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (frame_value !== 16'h0007 || got_q.size() != exp_q.size() || got_q.size() < 1) begin
            errors++;
            $display("FAIL reset_mid_frame value=%h frames=%0d required 0007 frames=%0d",
                     frame_value, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] sg;
        int         n;
        clear_scoreboard();
        for (int h = 0; h < 200; h++) begin
            do begin
                if ($urandom_range(4) != 0) a = ~(4'b0001 << $urandom_range(3));
                else a = 4'($urandom);
                if ($urandom_range(4) != 0) sg = glyph[$urandom_range(15)];
                else sg = 7'($urandom);
            end while (a == m_an && sg == m_seg);
            // Dwells either clearly short or clearly long enough.
            if ($urandom_range(3) == 0) n = $urandom_range(S - 1, 1);
            else n = $urandom_range(S + 6, S + 1);
            drive_hold(a, sg, n);
        end
        if (m_an == 4'hF && m_seg == 7'h7F) drive_hold(4'hE, 7'h7F, 1);
        drive_hold(4'hF, 7'h7F, S + 3);
        checks++;
        if (got_q.size() != exp_q.size() || got_bad != exp_bad) begin
            errors++;
            $display("FAIL random_events frames=%0d bad=%0d required frames=%0d bad=%0d",
                     got_q.size(), got_bad, exp_q.size(), exp_bad);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_frame[%0d] value=%h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            if (frame_value !== exp_q[exp_q.size() - 1]) begin
                errors++;
                $display("FAIL random_hold value=%h required %h", frame_value, exp_q[exp_q.size() - 1]);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset   = 1'b1;
        an      = 4'hF;
        seg     = 7'h7F;
        exp_bad = 0;
        got_bad = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_nominal();
        test_ghost();
        test_illegal();
        test_invalid_anode();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
# seg7_frame_decoder

Decodes the multiplexed, active-low 7-segment/anode bus of a 4-digit display back into a 16-bit hex value. It rejects mux-transition ghosting with a dwell filter. It sits on the display side of the design as a loopback monitor and self-check: it observes the same `seg`/`an` lines that drive the board display and reports each complete 4-digit frame, flagging segment patterns that are not legal hex glyphs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples of (`an`,`seg`) required before a digit is captured. Legal range 2..255.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `an`  input  4  active-low digit enables; `an[k]=0` selects digit k, where digit 0 is the rightmost/least significant.
- `seg`  input  7  active-low segments, bit0=a … bit6=g.
- `frame_value`  output  16  last completed frame; digit k occupies bits [4k+3:4k].
- `frame_valid`  output  1  one-cycle pulse when `frame_value` updates.
- `bad_seg`  output  1  one-cycle pulse when a captured pattern is not a legal glyph.

## Operation
- **Input stage.** `an`/`seg` are registered once into `s_an`/`s_seg`. Reset values are 4'hF and 7'h7F (blank).
- **Dwell counter** (8-bit):
  - If the current (`s_an`,`s_seg`) equals the previous cycle's pair, the counter increments, saturating at `STABLE_CYCLES`.
  - On any change it loads 1.
  - A capture fires exactly once per dwell, on the cycle the counter reaches `STABLE_CYCLES`. A saturated counter does not re-fire.
- **Capture qualification.** A capture is performed only if `s_an` has exactly one zero bit. All-ones (blank) or multiple zeros means no capture and no `bad_seg`.
- **Decode table** (`seg` → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F
  - Any other pattern is illegal.
- **Legal capture on digit k.**
  - The internal nibble k is overwritten and `seen[k]` is set.
  - A repeat capture of an already-seen digit overwrites the nibble; `seen` is unchanged.
- **Illegal capture on digit k.**
  - `bad_seg` pulses and `seen[k]` is cleared.
  - Nibble k is left unchanged.
- **Frame completion.**
  - Occurs when a legal capture results in `seen`=4'hF.
  - `frame_value` loads all four nibbles, including the nibble just captured.
  - `frame_valid` pulses and `seen` clears to 0.
- Digits may arrive in any order. Frames are not time-limited.

## Timing
- **Reset values:** `frame_value`=16'h0000, `frame_valid`=0, `bad_seg`=0, `seen`=0, counter=0, `s_an`=4'hF, `s_seg`=7'h7F.
- **Reset mid-operation:** reset asserted on any edge discards partial frame state. The first capture can occur no earlier than `STABLE_CYCLES`+1 edges after reset deasserts with steady inputs.
- **Capture latency:** if `an`/`seg` are steady at input edges E0…E0+`STABLE_CYCLES`, the capture edge is E0+`STABLE_CYCLES`. At that edge:
  - `frame_value`/`frame_valid` update for a completing capture;
  - `bad_seg` asserts for an illegal capture.
  
  Pulses are high for exactly the one cycle following that edge.
- A dwell of `STABLE_CYCLES`-1 samples, followed by a change, never captures.
- **Mux rate:** the display driver must hold each digit at least `STABLE_CYCLES`+1 clocks.
- `frame_valid` and `bad_seg` are mutually exclusive in any cycle.
- `frame_value` is held between frames.

## Test plan
- **Reset:** reset for 3 cycles with random `an`/`seg` → `frame_value`=0000, no pulses for 10 cycles after release with `an`=4'hF.
- **Nominal frame:** `STABLE_CYCLES`=4, drive digits 3,2,1,0 = 1,2,3,4 (patterns 1111001, 0100100, 0110000, 0011001), 8 clocks each → single `frame_valid` pulse, `frame_value`=16'h1234, pulse 4 clocks after digit-0 onset. Repeat with A,b,C,d → 16'hABCD.
- **Ghost rejection:** digit 0 = 0000000 held 3 clocks, then a 1-clock blank, then a full frame F,E,0,9 → `frame_value`=16'hFE09 (the ghost '8' never lands).
- **Illegal glyph:** digit 2 = 1111111 while `an`=4'b1011, held 8 clocks → one `bad_seg` pulse, no `frame_valid` until digit 2 is resent legally; then `frame_valid` fires.
- **Invalid anode:** `an`=4'b1100 or 4'hF with legal `seg` for 20 clocks → no capture, no pulses, `seen` unchanged.
- **Reset mid-frame:** capture digits 3,2,1, assert reset, then send only digit 0 → no `frame_valid`; a full new frame 0,0,0,7 → 16'h0007.
